// File: rtl/bus_timer_pkg.sv
// Shared constants for bus_timer: register offsets and CTRL/STATUS bit positions.
package bus_timer_pkg;

  localparam int unsigned OFF_W = 3;

  localparam logic [OFF_W-1:0] OFF_CTRL   = 3'd0;
  localparam logic [OFF_W-1:0] OFF_LOAD   = 3'd1;
  localparam logic [OFF_W-1:0] OFF_COUNT  = 3'd2;
  localparam logic [OFF_W-1:0] OFF_STATUS = 3'd3;
  localparam logic [OFF_W-1:0] OFF_PRESC  = 3'd4;

  localparam int unsigned CTRL_W      = 3;
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IE     = 2;
  localparam int unsigned STATUS_PEND = 0;

endpackage

// File: rtl/bus_timer_prescaler.sv
// Tick divider for bus_timer: one tick every presc+1 enabled cycles.
// Only built when BUS_TIMER_PRESCALE_EN is defined.
`ifdef BUS_TIMER_PRESCALE_EN
module timer_prescaler #(
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PRESC_WIDTH-1:0] presc,
  input  logic                   restart,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == presc);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + PRESC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/bus_timer.sv
// Bus-mapped countdown timer with one-shot/auto-reload and level interrupt.
// Define BUS_TIMER_PRESCALE_EN to add the PRESC register and tick prescaler.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int unsigned CPU_WIDTH   = 16,
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic [CPU_WIDTH-1:0] addr,
  input  logic                 ctrl,
  input  logic [CPU_WIDTH-1:0] wd,
  output logic [CPU_WIDTH-1:0] rd,
  output logic                 irq_timer
);

  logic [OFF_W-1:0]       off;
  logic                   unused_addr;
  logic                   wr_en, rd_en;
  logic                   wr_ctrl, wr_load, wr_status;
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
  logic [CPU_WIDTH-1:0]   load_q, load_d;
  logic [CPU_WIDTH-1:0]   count_q, count_d;
  logic                   pend_q, pend_d;
  logic                   tick, expire, en_rise;
  logic [PRESC_WIDTH-1:0] presc_rd;

  assign off         = addr[OFF_W-1:0];
  assign unused_addr = ^addr[CPU_WIDTH-1:OFF_W];

  assign wr_en     = sel & ctrl;
  assign rd_en     = sel & ~ctrl;
  assign wr_ctrl   = wr_en & (off == OFF_CTRL);
  assign wr_load   = wr_en & (off == OFF_LOAD);
  assign wr_status = wr_en & (off == OFF_STATUS);

  assign en_rise = wr_ctrl & wd[CTRL_EN] & ~ctrl_q[CTRL_EN];
  assign expire  = tick & (count_q == '0);

`ifdef BUS_TIMER_PRESCALE_EN
  logic                   wr_presc;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;

  assign wr_presc = wr_en & (off == OFF_PRESC);
  assign presc_d  = wr_presc ? wd[PRESC_WIDTH-1:0] : presc_q;
  assign presc_rd = presc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  timer_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (ctrl_q[CTRL_EN]),
    .presc   (presc_q),
    .restart (en_rise | wr_presc),
    .tick    (tick)
  );
`else
  assign tick     = ctrl_q[CTRL_EN];
  assign presc_rd = '0;
`endif

  // Countdown, expiry and register-write resolution.
  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    pend_d  = pend_q;

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - CPU_WIDTH'(1);
      end else if (ctrl_q[CTRL_AUTO]) begin
        count_d = load_q;
      end else begin
        ctrl_d[CTRL_EN] = 1'b0;
      end
    end

    if (wr_ctrl) begin
      ctrl_d = wd[CTRL_W-1:0];
      if (en_rise) begin
        count_d = load_q;
      end else if (expire && !wd[CTRL_EN]) begin
        // A disabling write on the expiry edge suppresses the reload.
        count_d = count_q;
      end
    end

    if (wr_load) begin
      load_d = wd;
    end

    if (wr_status && wd[STATUS_PEND]) begin
      pend_d = 1'b0;
    end
    if (expire) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    rd = '0;
    if (rd_en) begin
      case (off)
        OFF_CTRL:   rd = CPU_WIDTH'(ctrl_q);
        OFF_LOAD:   rd = load_q;
        OFF_COUNT:  rd = count_q;
        OFF_STATUS: rd[STATUS_PEND] = pend_q;
        OFF_PRESC:  rd = CPU_WIDTH'(presc_rd);
        default:    rd = '0;
      endcase
    end
  end

  assign irq_timer = pend_q & ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: directed bus sequences push expected reads,
// a monitor pops and compares rd and irq_timer when each read is presented.
module tb_bus_timer;

  localparam int unsigned CW = 16;

  localparam logic [2:0] R_CTRL   = 3'd0;
  localparam logic [2:0] R_LOAD   = 3'd1;
  localparam logic [2:0] R_COUNT  = 3'd2;
  localparam logic [2:0] R_STATUS = 3'd3;
  localparam logic [2:0] R_PRESC  = 3'd4;

`ifdef BUS_TIMER_PRESCALE_EN
  localparam logic [CW-1:0] PRESC_EXP = 16'd4;
`else
  localparam logic [CW-1:0] PRESC_EXP = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sel;
  logic          ctrl;
  logic [CW-1:0] addr;
  logic [CW-1:0] wd;
  logic [CW-1:0] rd;
  logic          irq_timer;

  typedef struct {
    string         name;
    logic [CW-1:0] rd;
    logic          irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  event chk_ev;

  bus_timer #(
    .CPU_WIDTH  (CW),
    .PRESC_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .addr     (addr),
    .ctrl     (ctrl),
    .wd       (wd),
    .rd       (rd),
    .irq_timer(irq_timer)
  );

  always #10 clk = ~clk;

  // Monitor: pops one expectation per presented read.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: read presented with no expectation");
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rd) begin
          failures++;
          $display("FAIL %s rd: got %h expected %h", e.name, rd, e.rd);
        end
        checks++;
        if (irq_timer !== e.irq) begin
          failures++;
          $display("FAIL %s irq_timer: got %b expected %b", e.name, irq_timer, e.irq);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [2:0] off, input logic [CW-1:0] data);
    sel  = 1'b1;
    ctrl = 1'b1;
    addr = 16'hA5A8 | CW'(off);
    wd   = data;
    @(posedge clk);
    #1;
    sel  = 1'b0;
    ctrl = 1'b0;
    addr = '0;
    wd   = '0;
  endtask

  task automatic wr_nosel(input logic [2:0] off, input logic [CW-1:0] data);
    sel  = 1'b0;
    ctrl = 1'b1;
    addr = CW'(off);
    wd   = data;
    @(posedge clk);
    #1;
    ctrl = 1'b0;
    addr = '0;
    wd   = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [2:0] off, input logic s,
                     input logic [CW-1:0] erd, input logic eirq);
    exp_t e;
    sel    = s;
    ctrl   = 1'b0;
    addr   = 16'hA5A8 | CW'(off);
    e.name = name;
    e.rd   = erd;
    e.irq  = eirq;
    exp_q.push_back(e);
    #1;
    ->chk_ev;
    #1;
    sel  = 1'b0;
    addr = '0;
  endtask

  task automatic rc(input string name, input logic [2:0] off,
                    input logic [CW-1:0] erd, input logic eirq);
    chk(name, off, 1'b1, erd, eirq);
  endtask

  initial begin
    rst  = 1'b1;
    sel  = 1'b0;
    ctrl = 1'b0;
    addr = '0;
    wd   = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) rc($sformatf("reset_off%0d", i), 3'(i), 16'h0, 1'b0);
    idle(1);
    rst = 1'b0;

    // One-shot
    wr(R_LOAD, 16'd3);
    rc("os_load", R_LOAD, 16'd3, 1'b0);
    wr(R_CTRL, 16'h5);
    rc("os_count_e0", R_COUNT, 16'd3, 1'b0);
    rc("os_ctrl_e0", R_CTRL, 16'h5, 1'b0);
    idle(3);
    rc("os_count_e3", R_COUNT, 16'd0, 1'b0);
    rc("os_pend_e3", R_STATUS, 16'd0, 1'b0);
    idle(1);
    rc("os_pend_e4", R_STATUS, 16'd1, 1'b1);
    rc("os_en_clear", R_CTRL, 16'h4, 1'b1);
    rc("os_count_zero", R_COUNT, 16'd0, 1'b1);
    idle(2);
    rc("os_count_held", R_COUNT, 16'd0, 1'b1);
    wr(R_STATUS, 16'h1);
    rc("os_w1c", R_STATUS, 16'd0, 1'b0);

    // Auto-reload and irq gap
    wr(R_CTRL, 16'h0);
    wr(R_LOAD, 16'd2);
    wr(R_CTRL, 16'h7);
    idle(2);
    rc("ar_count_e2", R_COUNT, 16'd0, 1'b0);
    rc("ar_pend_e2", R_STATUS, 16'd0, 1'b0);
    idle(1);
    rc("ar_pend_e3", R_STATUS, 16'd1, 1'b1);
    rc("ar_reload_e3", R_COUNT, 16'd2, 1'b1);
    wr(R_STATUS, 16'h1);
    rc("ar_gap_e4", R_STATUS, 16'd0, 1'b0);
    rc("ar_count_e4", R_COUNT, 16'd1, 1'b0);
    idle(1);
    rc("ar_gap_e5", R_STATUS, 16'd0, 1'b0);
    idle(1);
    rc("ar_pend_e6", R_STATUS, 16'd1, 1'b1);

    // Clear colliding with expiry
    idle(2);
    rc("col_pre", R_COUNT, 16'd0, 1'b1);
    wr(R_STATUS, 16'h1);
    rc("col_pend", R_STATUS, 16'd1, 1'b1);
    rc("col_reload", R_COUNT, 16'd2, 1'b1);
    wr(R_STATUS, 16'h1);
    rc("col_clear", R_STATUS, 16'd0, 1'b0);
    rc("col_count", R_COUNT, 16'd1, 1'b0);

    // Disabling CTRL write on the expiry edge
    idle(1);
    wr(R_CTRL, 16'h6);
    rc("dis_ctrl", R_CTRL, 16'h6, 1'b1);
    rc("dis_pend", R_STATUS, 16'd1, 1'b1);
    rc("dis_no_reload", R_COUNT, 16'd0, 1'b1);
    idle(3);
    rc("dis_count_hold", R_COUNT, 16'd0, 1'b1);
    wr(R_CTRL, 16'h2);
    rc("ie_off_irq", R_STATUS, 16'd1, 1'b0);
    wr(R_STATUS, 16'h1);
    rc("ie_off_clear", R_STATUS, 16'd0, 1'b0);

    // LOAD write while running applies at next reload
    wr(R_LOAD, 16'd5);
    wr(R_CTRL, 16'h7);
    idle(1);
    wr(R_LOAD, 16'd1);
    rc("lr_count", R_COUNT, 16'd3, 1'b0);
    rc("lr_load", R_LOAD, 16'd1, 1'b0);
    idle(3);
    rc("lr_count_e5", R_COUNT, 16'd0, 1'b0);
    idle(1);
    rc("lr_reload", R_COUNT, 16'd1, 1'b1);
    rc("lr_pend", R_STATUS, 16'd1, 1'b1);
    wr(R_CTRL, 16'h0);
    wr(R_STATUS, 16'h1);
    rc("lr_clear", R_STATUS, 16'd0, 1'b0);

    // LOAD=0 with AUTO expires every tick
    wr(R_LOAD, 16'd0);
    wr(R_CTRL, 16'h3);
    idle(1);
    rc("z_pend_e1", R_STATUS, 16'd1, 1'b0);
    rc("z_count_e1", R_COUNT, 16'd0, 1'b0);
    wr(R_STATUS, 16'h1);
    rc("z_pend_e2", R_STATUS, 16'd1, 1'b0);
    wr(R_CTRL, 16'h0);
    wr(R_STATUS, 16'h1);
    rc("z_clear", R_STATUS, 16'd0, 1'b0);
    rc("z_ctrl", R_CTRL, 16'h0, 1'b0);

    // Prescaler
    wr(R_PRESC, 16'd4);
    rc("presc_rd", R_PRESC, PRESC_EXP, 1'b0);
    wr(R_LOAD, 16'd1);
    wr(R_CTRL, 16'h3);
`ifdef BUS_TIMER_PRESCALE_EN
    idle(9);
    rc("ps_pend_e9", R_STATUS, 16'd0, 1'b0);
    rc("ps_count_e9", R_COUNT, 16'd0, 1'b0);
    idle(1);
    rc("ps_pend_e10", R_STATUS, 16'd1, 1'b0);
    rc("ps_count_e10", R_COUNT, 16'd1, 1'b0);
    wr(R_STATUS, 16'h1);
    rc("ps_clear", R_STATUS, 16'd0, 1'b0);
    idle(8);
    rc("ps_pend_e19", R_STATUS, 16'd0, 1'b0);
    idle(1);
    rc("ps_pend_e20", R_STATUS, 16'd1, 1'b0);
`else
    idle(1);
    rc("ps_pend_e1", R_STATUS, 16'd0, 1'b0);
    rc("ps_count_e1", R_COUNT, 16'd0, 1'b0);
    idle(1);
    rc("ps_pend_e2", R_STATUS, 16'd1, 1'b0);
    rc("ps_count_e2", R_COUNT, 16'd1, 1'b0);
    wr(R_STATUS, 16'h1);
    rc("ps_clear", R_STATUS, 16'd0, 1'b0);
    idle(1);
    rc("ps_pend_e4", R_STATUS, 16'd1, 1'b0);
`endif
    wr(R_CTRL, 16'h0);
    wr(R_STATUS, 16'h1);
    wr(R_PRESC, 16'd0);

    // Reset mid-count
    wr(R_LOAD, 16'd100);
    wr(R_CTRL, 16'h7);
    idle(20);
    rc("rm_count_e20", R_COUNT, 16'd80, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) rc($sformatf("rm_in_reset_off%0d", i), 3'(i), 16'h0, 1'b0);
    idle(2);
    rst = 1'b0;
    idle(200);
    rc("rm_status", R_STATUS, 16'd0, 1'b0);
    rc("rm_count", R_COUNT, 16'd0, 1'b0);
    rc("rm_ctrl", R_CTRL, 16'h0, 1'b0);
    rc("rm_load", R_LOAD, 16'd0, 1'b0);

    // Bus isolation and reserved offsets
    wr(R_LOAD, 16'h1234);
    rc("iso_load", R_LOAD, 16'h1234, 1'b0);
    wr_nosel(R_LOAD, 16'hBEEF);
    rc("iso_load_nosel", R_LOAD, 16'h1234, 1'b0);
    wr_nosel(R_CTRL, 16'h0007);
    rc("iso_ctrl_nosel", R_CTRL, 16'h0, 1'b0);
    chk("iso_rd_sel0", R_LOAD, 1'b0, 16'h0, 1'b0);
    for (int i = 5; i < 8; i++) wr(3'(i), 16'hFFFF);
    for (int i = 5; i < 8; i++) rc($sformatf("iso_rsvd%0d", i), 3'(i), 16'h0, 1'b0);
    rc("iso_rsvd_load", R_LOAD, 16'h1234, 1'b0);
    rc("iso_rsvd_status", R_STATUS, 16'd0, 1'b0);
    rc("iso_rsvd_presc", R_PRESC, 16'd0, 1'b0);
    wr(R_CTRL, 16'hFFF8);
    rc("ctrl_upper_bits", R_CTRL, 16'h0, 1'b0);
    rc("ctrl_upper_count", R_COUNT, 16'd0, 1'b0);

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter CPU_WIDTH, default 16, setting the bus data/address width.
REQ-002 SHALL have parameter PRESC_WIDTH, default 8, setting the prescaler register width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-005 SHALL have port sel, input, 1, chip select from bus address decode.
REQ-006 SHALL have port addr, input, CPU_WIDTH; only bits [2:0] are decoded as the register offset.
REQ-007 SHALL have port ctrl, input, 1; 1 = write, 0 = read.
REQ-008 SHALL have port wd, input, CPU_WIDTH, write data.
REQ-009 SHALL have port rd, output, CPU_WIDTH, read data.
REQ-010 SHALL have port irq_timer, output, 1, level interrupt to the CPU irq vector.

Function
REQ-011 SHALL provide registers: 0 CTRL (bit0 EN, bit1 AUTO, bit2 IE, other bits 0); 1 LOAD (R/W); 2 COUNT (read-only); 3 STATUS (bit0 PEND, write-1-clear); 4 PRESC; 5-7 reserved (read 0, writes ignored).
REQ-012 SHALL commit a write on the clk edge where sel=1 and ctrl=1; no write occurs when sel=0.
REQ-013 SHALL drive rd combinationally (zero-cycle latency) with the addressed register when sel=1 and ctrl=0, otherwise 0.
REQ-014 SHALL generate a tick every cycle while EN=1, subject to REQ-031.
REQ-015 SHALL load COUNT from LOAD on the edge where a CTRL write changes EN from 0 to 1.
REQ-016 SHALL decrement COUNT by 1 on each tick when COUNT>0.
REQ-017 SHALL, on a tick with COUNT=0 (expiry): set PEND; reload COUNT from LOAD if AUTO=1; otherwise clear EN and hold COUNT at 0.
REQ-018 SHALL apply a LOAD write while running only at the next reload; it SHALL NOT change COUNT immediately.
REQ-019 SHALL, with LOAD=0 and AUTO=1, expire on every tick.
REQ-020 SHALL let expiry win when a STATUS write-1-clear and an expiry occur on the same edge (PEND stays 1).
REQ-021 SHALL let a same-edge CTRL write with EN=0 win over an expiry reload; PEND is still set.
REQ-022 SHALL hold COUNT unchanged while EN=0.
REQ-023 SHALL drive irq_timer = PEND & IE as a registered-state level; it stays high until PEND is cleared or IE is written 0.

Reset
REQ-024 SHALL asynchronously set CTRL, LOAD, COUNT, PEND, PRESC and the prescaler counter to 0 when rst=1.
REQ-025 SHALL hold irq_timer=0 during reset; rd follows REQ-013 and reads 0 from every register.
REQ-026 SHALL abandon any countdown in progress when reset is asserted mid-operation; no expiry follows reset release.

Configuration
REQ-027 SHALL recognise the macro BUS_TIMER_PRESCALE_EN.
REQ-028 SHALL, when the macro is defined, implement PRESC[PRESC_WIDTH-1:0] and an internal counter producing one tick every PRESC+1 cycles while EN=1.
REQ-029 SHALL, when the macro is defined, reset the prescaler counter to 0 whenever EN goes 0 to 1 or PRESC is written.
REQ-030 SHALL, when the macro is undefined, read PRESC as 0, ignore PRESC writes, and tick every cycle while EN=1.
REQ-031 SHALL derive ticks from the prescaler under REQ-028 when the macro is defined.

Structure
REQ-032 SHALL take register offsets (0-4) and CTRL/STATUS bit positions from the shared project constants header, not from local literals.
REQ-033 SHALL implement the prescaler as one sub-module, timer_prescaler (inputs clk, rst, en, presc, restart; output tick), instantiated only under BUS_TIMER_PRESCALE_EN.

Verification
REQ-034 SHALL cover one-shot: LOAD=3, CTRL=0x5 -> PEND and irq_timer rise on the 4th edge after the CTRL write; EN reads 0; COUNT holds 0.
REQ-035 SHALL cover auto-reload: LOAD=2, CTRL=0x7 -> PEND set every 3 cycles; write STATUS=1 between expiries -> irq_timer drops for exactly that gap.
REQ-036 SHALL cover the clear/expiry collision: STATUS=1 written on the expiry edge -> PEND remains 1 and irq_timer stays high.
REQ-037 SHALL cover the prescaler: with the macro defined, PRESC=4, LOAD=1, CTRL=0x3 -> expiry every 10 cycles; with the macro undefined -> every 2 cycles and PRESC reads 0.
REQ-038 SHALL cover reset mid-count: LOAD=100, run 20 cycles, pulse rst -> all reads 0, irq_timer=0, no expiry within 200 cycles.
REQ-039 SHALL cover bus isolation: writes with sel=0 and writes to offsets 5-7 -> no register change; rd=0 whenever sel=0.
